// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60Hz raster constants and types for the VGA sync generator.
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FRONT  = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FRONT  = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;

    localparam int H_TOTAL = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int V_TOTAL = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam int CNT_W = 10;
    localparam int RGB_W = 6;

    localparam logic [RGB_W-1:0] RGB_WHITE = '1;
    localparam logic [RGB_W-1:0] RGB_BLACK = '0;

    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } sync_t;

    localparam int SYNC_W = $bits(sync_t);

endpackage

// File: rtl/sync_delay_line.sv
// Enable-gated shift register that keeps sync/blank decode aligned with the
// PPU pixel pipeline; the reset value is fixed by the parent.
module sync_delay_line #(
    parameter int               DEPTH   = 3,
    parameter int               WIDTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else if (en_i) begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_sync_generator.sv
// 640x480@60Hz raster counters plus pipeline-aligned hsync/vsync/rgb for the PPU.
// Define VGA_PIXEL_DIV2_EN to run from a 50 MHz clock with a divide-by-two pixel strobe.
module vga_sync_generator
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE    = VGA_H_ACTIVE,
    parameter int   H_FRONT     = VGA_H_FRONT,
    parameter int   H_SYNC      = VGA_H_SYNC,
    parameter int   H_BACK      = VGA_H_BACK,
    parameter int   V_ACTIVE    = VGA_V_ACTIVE,
    parameter int   V_FRONT     = VGA_V_FRONT,
    parameter int   V_SYNC      = VGA_V_SYNC,
    parameter int   V_BACK      = VGA_V_BACK,
    parameter int   PIPE_DELAY  = 3,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             colour_in,
    output logic [CNT_W-1:0] counter_H,
    output logic [CNT_W-1:0] counter_V,
    output logic             hsync,
    output logic             vsync,
    output logic [RGB_W-1:0] rgb,
    output logic             display_on,
    output logic             frame_end
);

    localparam int LOC_H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int LOC_V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(LOC_H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(LOC_V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC - 1);

    localparam sync_t DLY_RST = '{hs: 1'b0, vs: 1'b0, act: 1'b0};

    logic pix;

`ifdef VGA_PIXEL_DIV2_EN
    logic pix_q;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            pix_q <= 1'b0;
        end else begin
            pix_q <= ~pix_q;
        end
    end

    assign pix = pix_q;
`else
    assign pix = 1'b1;
`endif

    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             frame_end_q, frame_end_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             display_on_q, display_on_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;

    sync_t raw;
    sync_t dly;

    always_comb begin
        h_d = h_q + CNT_ONE;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : (v_q + CNT_ONE);
        end
        // Decoded from the next count so the registered pulse lines up with (H_LAST, V_LAST).
        frame_end_d = (h_d == H_LAST) && (v_d == V_LAST);
    end

    always_comb begin
        raw.hs  = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
        raw.vs  = (v_q >= VS_FIRST) && (v_q <= VS_LAST);
        raw.act = (h_q < H_VIS) && (v_q < V_VIS);
    end

    sync_delay_line #(
        .DEPTH   (PIPE_DELAY),
        .WIDTH   (SYNC_W),
        .RST_VAL (DLY_RST)
    ) u_sync_delay (
        .clk_i (clk_in),
        .rst_i (reset),
        .en_i  (pix),
        .d_i   (raw),
        .q_o   (dly)
    );

    always_comb begin
        hsync_d      = dly.hs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d      = dly.vs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        display_on_d = dly.act;
        rgb_d        = RGB_BLACK;
        if (dly.act && colour_in) begin
            rgb_d = RGB_WHITE;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            h_q          <= '0;
            v_q          <= '0;
            frame_end_q  <= 1'b0;
            hsync_q      <= ~SYNC_ACTIVE;
            vsync_q      <= ~SYNC_ACTIVE;
            display_on_q <= 1'b0;
            rgb_q        <= RGB_BLACK;
        end else if (pix) begin
            h_q          <= h_d;
            v_q          <= v_d;
            frame_end_q  <= frame_end_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            display_on_q <= display_on_d;
            rgb_q        <= rgb_d;
        end
    end

    assign counter_H  = h_q;
    assign counter_V  = v_q;
    assign frame_end  = frame_end_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign display_on = display_on_q;
    assign rgb        = rgb_q;

endmodule

// File: tb/tb_vga_sync_generator.sv
// Bench for vga_sync_generator: a full-size instance plus a miniature-timing
// instance, both checked every clock against a position-arithmetic raster model.
module tb_vga_sync_generator;

`ifdef VGA_PIXEL_DIV2_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 1;
`endif

    localparam int HA [2] = '{640, 16};
    localparam int HF [2] = '{16, 4};
    localparam int HS [2] = '{96, 6};
    localparam int HB [2] = '{48, 4};
    localparam int VA [2] = '{480, 12};
    localparam int VF [2] = '{10, 2};
    localparam int VS [2] = '{2, 2};
    localparam int VB [2] = '{33, 3};
    localparam int PD [2] = '{3, 5};
    localparam bit SA [2] = '{1'b0, 1'b1};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic colour = 1'b0;

    logic [9:0] ch [2];
    logic [9:0] cv [2];
    logic       hs_o [2];
    logic       vs_o [2];
    logic       don [2];
    logic       fe [2];
    logic [5:0] rgb_o [2];

    int  total = 0;
    int  bad = 0;
    int  s = 0;
    int  nclk = 0;
    logic col_s = 1'b0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    vga_sync_generator u_dut0 (
        .clk_in     (clk),
        .reset      (reset),
        .colour_in  (colour),
        .counter_H  (ch[0]),
        .counter_V  (cv[0]),
        .hsync      (hs_o[0]),
        .vsync      (vs_o[0]),
        .rgb        (rgb_o[0]),
        .display_on (don[0]),
        .frame_end  (fe[0])
    );

    vga_sync_generator #(
        .H_ACTIVE (16), .H_FRONT (4), .H_SYNC (6), .H_BACK (4),
        .V_ACTIVE (12), .V_FRONT (2), .V_SYNC (2), .V_BACK (3),
        .PIPE_DELAY (5), .SYNC_ACTIVE (1'b1)
    ) u_dut1 (
        .clk_in     (clk),
        .reset      (reset),
        .colour_in  (colour),
        .counter_H  (ch[1]),
        .counter_V  (cv[1]),
        .hsync      (hs_o[1]),
        .vsync      (vs_o[1]),
        .rgb        (rgb_o[1]),
        .display_on (don[1]),
        .frame_end  (fe[1])
    );

    // Model time base: s = pixel strobes since reset release, col_s = colour at the latest strobe.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            nclk  = 0;
            s     = 0;
            col_s = 1'b0;
        end else begin
            nclk = nclk + 1;
            if (nclk % DIV == 0) begin
                s     = s + 1;
                col_s = colour;
            end
        end
    end

    task automatic chk(input string name, input int d, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s dut%0d s=%0d got=%0h want=%0h", name, d, s, got, want);
        end
    endtask

    task automatic cmp_dut(input int d);
        int ht, vt, ft, pos, t, p2, h2, v2;
        logic ehs, evs, eact;
        ht  = HA[d] + HF[d] + HS[d] + HB[d];
        vt  = VA[d] + VF[d] + VS[d] + VB[d];
        ft  = ht * vt;
        pos = s % ft;
        t   = s - PD[d] - 1;
        ehs = 1'b0;
        evs = 1'b0;
        eact = 1'b0;
        if (t >= 0) begin
            p2   = t % ft;
            h2   = p2 % ht;
            v2   = p2 / ht;
            ehs  = (h2 >= HA[d] + HF[d]) && (h2 < HA[d] + HF[d] + HS[d]);
            evs  = (v2 >= VA[d] + VF[d]) && (v2 < VA[d] + VF[d] + VS[d]);
            eact = (h2 < HA[d]) && (v2 < VA[d]);
        end
        chk("counter_H", d, 32'(ch[d]), pos % ht);
        chk("counter_V", d, 32'(cv[d]), pos / ht);
        chk("frame_end", d, 32'(fe[d]), (pos == ft - 1) ? 32'd1 : 32'd0);
        chk("hsync", d, 32'(hs_o[d]), 32'(ehs ? SA[d] : !SA[d]));
        chk("vsync", d, 32'(vs_o[d]), 32'(evs ? SA[d] : !SA[d]));
        chk("display_on", d, 32'(don[d]), 32'(eact));
        chk("rgb", d, 32'(rgb_o[d]), (eact && col_s) ? 32'h3F : 32'h0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_dut(0);
            cmp_dut(1);
        end
    end

    // mode 0: random colour, 1: colour held high, 2: single pulse while s == pk
    task automatic run_to(input int target, input int mode, input int pk);
        int g;
        g = 0;
        while (s != target && g < 20000) begin
            @(negedge clk);
            g++;
            case (mode)
                0:       colour = 1'($urandom_range(0, 1));
                1:       colour = 1'b1;
                default: colour = (s == pk);
            endcase
        end
        if (s != target) begin
            total++;
            bad++;
            $display("FAIL run_to timeout s=%0d want=%0d", s, target);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);

        chk("rst_counter_H", 0, 32'(ch[0]), 0);
        chk("rst_counter_V", 0, 32'(cv[0]), 0);
        chk("rst_hsync", 0, 32'(hs_o[0]), 1);
        chk("rst_vsync", 0, 32'(vs_o[0]), 1);
        chk("rst_rgb", 0, 32'(rgb_o[0]), 0);
        chk("rst_display_on", 0, 32'(don[0]), 0);
        chk("rst_frame_end", 0, 32'(fe[0]), 0);
        chk("rst_hsync", 1, 32'(hs_o[1]), 0);

        reset = 1'b0;
        run_to(1, 0, 0);
        chk("first_count", 0, 32'(ch[0]), 1);
        chk("first_count", 1, 32'(ch[1]), 1);

        run_to(425, 0, 0);
        chk("vsync_pre", 1, 32'(vs_o[1]), 0);
        run_to(426, 0, 0);
        chk("vsync_rise", 1, 32'(vs_o[1]), 1);
        run_to(485, 0, 0);
        chk("vsync_hold", 1, 32'(vs_o[1]), 1);
        run_to(486, 0, 0);
        chk("vsync_fall", 1, 32'(vs_o[1]), 0);

        run_to(568, 0, 0);
        chk("frame_end_pre", 1, 32'(fe[1]), 0);
        run_to(569, 0, 0);
        chk("frame_end_hi", 1, 32'(fe[1]), 1);
        chk("frame_last_H", 1, 32'(ch[1]), 29);
        chk("frame_last_V", 1, 32'(cv[1]), 18);
        run_to(570, 0, 0);
        chk("frame_end_lo", 1, 32'(fe[1]), 0);
        chk("frame_wrap_H", 1, 32'(ch[1]), 0);
        chk("frame_wrap_V", 1, 32'(cv[1]), 0);

        run_to(659, 0, 0);
        chk("hsync_pre", 0, 32'(hs_o[0]), 1);
        run_to(660, 0, 0);
        chk("hsync_fall", 0, 32'(hs_o[0]), 0);
        run_to(755, 0, 0);
        chk("hsync_hold", 0, 32'(hs_o[0]), 0);
        run_to(756, 0, 0);
        chk("hsync_rise", 0, 32'(hs_o[0]), 1);

        run_to(1599, 0, 0);
        chk("line_last_H", 0, 32'(ch[0]), 799);
        chk("line_last_V", 0, 32'(cv[0]), 1);
        run_to(1600, 0, 0);
        chk("line_wrap_H", 0, 32'(ch[0]), 0);
        chk("line_wrap_V", 0, 32'(cv[0]), 2);

        // Counter value 1700 is (100,2); its colour arrives three strobes later.
        run_to(1699, 0, 0);
        run_to(1703, 2, 1703);
        chk("pulse_before", 0, 32'(rgb_o[0]), 0);
        run_to(1704, 2, 1703);
        chk("pulse_rgb", 0, 32'(rgb_o[0]), 32'h3F);
        chk("pulse_display_on", 0, 32'(don[0]), 1);
        run_to(1705, 2, 1703);
        chk("pulse_after", 0, 32'(rgb_o[0]), 0);

        run_to(1900, 0, 0);
        chk("mid_H", 0, 32'(ch[0]), 300);
        chk("mid_V", 0, 32'(cv[0]), 2);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_H", 0, 32'(ch[0]), 0);
        chk("mid_rst_V", 0, 32'(cv[0]), 0);
        chk("mid_rst_hsync", 0, 32'(hs_o[0]), 1);
        chk("mid_rst_vsync", 0, 32'(vs_o[0]), 1);
        chk("mid_rst_rgb", 0, 32'(rgb_o[0]), 0);
        chk("mid_rst_display_on", 0, 32'(don[0]), 0);
        chk("mid_rst_frame_end", 0, 32'(fe[0]), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_to(1, 1, 0);
        chk("restart_H", 0, 32'(ch[0]), 1);
        chk("restart_V", 0, 32'(cv[0]), 0);

        run_to(700, 1, 0);
        run_to(1000, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
